// File: rtl/bus_cycle_master_8088.sv
// bus_cycle_master_8088
//   8088 minimum-mode bus initiator. Each request accepted on the req port
//   becomes one T1-T2-T3-[TW...]-T4 bus cycle. T4 is always followed by at
//   least one IDLE cycle. All bus-side outputs are registered. req_ready is
//   decoded from the state and gated by RESET_N.
//
//   Optional feature (macro WAIT_TIMEOUT_EN): abort a cycle after MAX_WAIT
//   consecutive TW states and flag it with rsp_err. When the macro is
//   undefined, TW waits forever and rsp_err is tied to 0.
//
// Ports
//   CLK, RESET_N            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_write, req_io       cycle type (write/read, IO/memory)
//   req_addr[19:0]          byte address; IO cycles drive A[19:16] = 0
//   req_wdata[7:0]          write data
//   rsp_valid               one-cycle completion pulse (during T4)
//   rsp_rdata[7:0]          read data, held until the next read capture
//   rsp_err                 timeout abort flag, valid with rsp_valid
//   A[11:0]                 address bits 19:8
//   AD[7:0]                 multiplexed address/data (tri-state)
//   ALE, IOM, RD, WR, DTR, DEN, READY   8088 bus control pins
module bus_cycle_master_8088 #(
    parameter int MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [11:0] A,
    inout  wire  [7:0]  AD,
    output logic        ALE,
    output logic        IOM,
    output logic        RD,
    output logic        WR,
    output logic        DTR,
    output logic        DEN,
    input  logic        READY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_TW,
        S_T4
    } state_t;

    state_t      state;
    logic        lat_write;
    logic [7:0]  lat_wdata;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic        timeout;

    // Reject a zero wait limit at elaboration time.
    if (MAX_WAIT < 1) begin : g_max_wait_check
        $error("MAX_WAIT must be at least 1");
    end

`ifdef WAIT_TIMEOUT_EN
    localparam int CW = (MAX_WAIT > 15) ? $clog2(MAX_WAIT + 1) : 4;
    logic [CW-1:0] wait_cnt;   // number of TW states entered so far
    logic          err_q;
    assign timeout = (wait_cnt == CW'(MAX_WAIT));
    assign rsp_err = err_q;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign AD        = ad_oe ? ad_out : 8'bz;
    assign req_ready = RESET_N && (state == S_IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            lat_write <= 1'b0;
            lat_wdata <= 8'h00;
            ad_out    <= 8'h00;
            ad_oe     <= 1'b0;
            A         <= 12'h000;
            ALE       <= 1'b0;
            IOM       <= 1'b0;
            DTR       <= 1'b0;
            RD        <= 1'b1;
            WR        <= 1'b1;
            DEN       <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
`ifdef WAIT_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef WAIT_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // req_ready is 1 here, so req_valid alone means acceptance.
                    if (req_valid) begin
                        state     <= S_T1;
                        lat_write <= req_write;
                        lat_wdata <= req_wdata;
                        ALE       <= 1'b1;
                        IOM       <= req_io;
                        DTR       <= req_write;
                        A         <= req_io ? {4'h0, req_addr[15:8]} : req_addr[19:8];
                        ad_out    <= req_addr[7:0];
                        ad_oe     <= 1'b1;
                    end
                end
                S_T1: begin
                    state <= S_T2;
                    ALE   <= 1'b0;
                    DEN   <= 1'b0;
                    if (lat_write) begin
                        WR     <= 1'b0;
                        ad_out <= lat_wdata;
                    end else begin
                        RD    <= 1'b0;
                        ad_oe <= 1'b0;   // release AD for the responder
                    end
                end
                S_T2: state <= S_T3;
                S_T3, S_TW: begin
                    if (READY) begin
                        state     <= S_T4;
                        RD        <= 1'b1;
                        WR        <= 1'b1;
                        DEN       <= 1'b1;
                        rsp_valid <= 1'b1;
                        if (!lat_write) rsp_rdata <= AD;
                    end else if (state == S_TW && timeout) begin
                        // Abort: finish the cycle without touching rsp_rdata.
                        state     <= S_T4;
                        RD        <= 1'b1;
                        WR        <= 1'b1;
                        DEN       <= 1'b1;
                        rsp_valid <= 1'b1;
`ifdef WAIT_TIMEOUT_EN
                        err_q     <= 1'b1;
`endif
                    end else begin
                        state <= S_TW;
`ifdef WAIT_TIMEOUT_EN
                        wait_cnt <= (state == S_T3) ? CW'(1) : wait_cnt + CW'(1);
`endif
                    end
                end
                S_T4: begin
                    // Write data was held through T4; float AD going idle.
                    state <= S_IDLE;
                    ad_oe <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cycle_master_8088.sv
// tb_bus_cycle_master_8088
//   Bench for bus_cycle_master_8088. The reference model tracks each bus
//   cycle as a count of clocks since acceptance and derives every expected
//   pin value from that count, the cycle type and the wait-state count the
//   bench itself chose. The bench also acts as the responder: it drives AD
//   whenever the master must not, and it stores written bytes.
module tb_bus_cycle_master_8088;
    localparam int MAXW = 15;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_io = 1'b0;
    logic [19:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        READY = 1'b1;
    logic        req_ready, rsp_valid, rsp_err, ALE, IOM, RD, WR, DTR, DEN;
    logic [7:0]  rsp_rdata;
    logic [11:0] A;
    wire  [7:0]  AD;
    logic        tb_oe = 1'b1;
    logic [7:0]  tb_data = 8'h00;

    assign AD = tb_oe ? tb_data : 8'bz;

    bus_cycle_master_8088 #(.MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .A(A), .AD(AD), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
        .DTR(DTR), .DEN(DEN), .READY(READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic        io;
        logic [19:0] addr;
        logic [7:0]  wd;
        int          w;         // clocks READY is held low from T3 on
        int          force_rd;  // responder read data, or -1 for random
    } req_t;

    req_t        pend[$];
    req_t        cur;
    int          k = 0;         // 0 = idle, else clock index since acceptance (1 = T1)
    int          t4 = 4, weff = 0, cyc = 0;
    logic        err = 1'b0;
    logic [11:0] exp_a = '0;
    logic        exp_iom = 1'b0, exp_dtr = 1'b0;
    logic [7:0]  exp_rdata = '0;
    int          checks = 0, errors = 0;

    logic [7:0]  mem [int];
    logic [19:0] lat_addr = '0;
    logic        lat_io = 1'b0;
    int          t1_cyc = 0, rsp_cyc = 0, n_rsp = 0;
    logic [11:0] t1_a = '0;
    logic [7:0]  t1_ad = '0;
    logic        t1_iom = 1'b0, t1_dtr = 1'b0, last_err = 1'b0;
    int          ale_cycs[$];
    logic        e_ale, e_rd, e_wr, e_den, e_rv, e_err, e_rr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] a_of(input req_t r);
        return r.io ? {4'h0, r.addr[15:8]} : r.addr[19:8];
    endfunction

    function automatic logic [7:0] mem_rd(input int key);
        return mem.exists(key) ? mem[key] : 8'h00;
    endfunction

    // Drive inputs for the clock that has just begun.
    task automatic drive();
        req_valid = pend.size() > 0;
        if (req_valid) begin
            req_write = pend[0].wr;   req_io    = pend[0].io;
            req_addr  = pend[0].addr; req_wdata = pend[0].wd;
        end else begin
            req_write = 1'($urandom); req_io    = 1'($urandom);
            req_addr  = 20'($urandom); req_wdata = 8'($urandom);
        end
        if (k >= 3 && k < 3 + cur.w)      READY = 1'b0;
        else if (k > 0 && k == 3 + cur.w) READY = 1'b1;
        else                              READY = 1'($urandom);
        tb_oe   = !(RESET_N && (k == 1 || (k >= 2 && cur.wr)));
        tb_data = 8'($urandom);
        if (k >= 2 && !cur.wr && cur.force_rd >= 0) tb_data = 8'(cur.force_rd);
    endtask

    // Advance the model across one rising edge, then drive the next clock.
    task automatic step();
        @(posedge CLK);
        cyc++;
        if (!RESET_N) k = 0;
        else if (k == 0) begin
            if (req_valid) begin
                cur = pend.pop_front();
                k = 1;
`ifdef WAIT_TIMEOUT_EN
                err  = cur.w > MAXW;
                weff = err ? MAXW : cur.w;
`else
                err  = 1'b0;
                weff = cur.w;
`endif
                t4 = 4 + weff;
                exp_a = a_of(cur); exp_iom = cur.io; exp_dtr = cur.wr;
            end
        end else if (k == t4) k = 0;
        else begin
            k++;
            // Read data is whatever the responder drove in the last T3/TW.
            if (k == t4 && !cur.wr && !err) exp_rdata = tb_data;
        end
        #1;
        drive();
    endtask

    task automatic run(input int budget);
        int n = 0;
        do begin step(); n++; end while ((pend.size() > 0 || k != 0) && n < budget);
        if (pend.size() > 0 || k != 0) chk("cycle_budget", 32'(k), 32'(0));
    endtask

    // Compare process: every clock, DUT pins against the model.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            chk("reset_ctrl", {ALE, RD, WR, DEN, DTR, IOM, req_ready, rsp_valid, rsp_err}, 9'b011100000);
            chk("reset_a", A, 0);
            chk("reset_rdata", rsp_rdata, 0);
            chk("reset_ad_float", AD, tb_data);
        end else begin
            {e_ale, e_rd, e_wr, e_den, e_rv, e_err, e_rr} = 7'b0111001;
            if (k == 1) begin
                e_ale = 1'b1; e_rr = 1'b0;
            end else if (k >= 2 && k < t4) begin
                e_rd = cur.wr; e_wr = !cur.wr; e_den = 1'b0; e_rr = 1'b0;
            end else if (k != 0 && k == t4) begin
                e_rv = 1'b1; e_err = err; e_rr = 1'b0;
            end
            chk("ctrl", {ALE, RD, WR, DEN, rsp_valid, rsp_err, req_ready},
                {e_ale, e_rd, e_wr, e_den, e_rv, e_err, e_rr});
            chk("addr_hi", A, exp_a);
            chk("iom_dtr", {IOM, DTR}, {exp_iom, exp_dtr});
            chk("rdata", rsp_rdata, exp_rdata);
            if (k == 1)                  chk("ad_addr", AD, cur.addr[7:0]);
            else if (k >= 2 && cur.wr)   chk("ad_wdata", AD, cur.wd);
            else                         chk("ad_float", AD, tb_data);
            if (ALE) begin
                lat_addr = {A, AD}; lat_io = IOM;
                t1_cyc = cyc; t1_a = A; t1_ad = AD; t1_iom = IOM; t1_dtr = DTR;
                ale_cycs.push_back(cyc);
            end
            if (rsp_valid) begin
                rsp_cyc = cyc; n_rsp++; last_err = rsp_err;
            end
        end
    end

    // Responder write port: store AD while WR is low and READY is high.
    always @(posedge CLK)
        if (RESET_N && !WR && READY) mem[int'({lat_io, lat_addr})] = AD;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, b0;
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        drive();
        #1 chk("ready_after_reset", req_ready, 1);

        // Memory read, zero waits, responder returns 0xA5.
        pend.push_back('{1'b0, 1'b0, 20'h81234, 8'h00, 0, 'hA5});
        run(20);
        chk("rd_t1_a", t1_a, 12'h812);
        chk("rd_t1_ad", t1_ad, 8'h34);
        chk("rd_t1_iom", t1_iom, 0);
        chk("rd_data", rsp_rdata, 8'hA5);
        chk("rd_latency", 32'(rsp_cyc - t1_cyc), 3);

        // IO write.
        pend.push_back('{1'b1, 1'b1, 20'h0FF05, 8'h3C, 0, -1});
        run(20);
        chk("wr_t1_a", t1_a, 12'h0FF);
        chk("wr_t1_ad", t1_ad, 8'h05);
        chk("wr_t1_iom_dtr", {t1_iom, t1_dtr}, 2'b11);
        chk("wr_port", mem_rd(int'({1'b1, 20'h0FF05})), 8'h3C);

        // Two wait states.
        pend.push_back('{1'b0, 1'b0, 20'h12345, 8'h00, 2, -1});
        run(20);
        chk("wait_latency", 32'(rsp_cyc - t1_cyc), 5);

        // Back-to-back requests with req_valid held high.
        ale_cycs.delete();
        pend.push_back('{1'b0, 1'b1, 20'h00042, 8'h00, 0, -1});
        pend.push_back('{1'b1, 1'b0, 20'hABCDE, 8'h77, 0, -1});
        run(30);
        chk("b2b_count", 32'(ale_cycs.size()), 2);
        if (ale_cycs.size() == 2) chk("b2b_spacing", 32'(ale_cycs[1] - ale_cycs[0]), 5);

        // Reset during T3 of a write.
        pend.push_back('{1'b1, 1'b0, 20'h54321, 8'h99, 3, -1});
        n = 0;
        do begin step(); n++; end while (k != 3 && n < 10);
        chk("reached_t3", 32'(k), 3);
        b0 = n_rsp;
        #2;
        RESET_N = 1'b0;
        k = 0; exp_a = '0; exp_iom = 1'b0; exp_dtr = 1'b0; exp_rdata = '0;
        pend.delete();
        tb_oe = 1'b1;
        step();
        step();
        RESET_N = 1'b1;
        drive();
        #1 chk("ready_after_abort", req_ready, 1);
        chk("no_rsp_on_abort", 32'(n_rsp - b0), 0);
        pend.push_back('{1'b0, 1'b0, 20'h0BEEF, 8'h00, 1, 'h5A});
        run(20);
        chk("read_after_reset", rsp_rdata, 8'h5A);

        // READY held low for 20 clocks from T3.
        pend.push_back('{1'b0, 1'b0, 20'h33333, 8'h00, 20, -1});
        run(60);
`ifdef WAIT_TIMEOUT_EN
        chk("timeout_latency", 32'(rsp_cyc - t1_cyc), 3 + MAXW);
        chk("timeout_err", last_err, 1);
        chk("timeout_keeps_rdata", rsp_rdata, 8'h5A);
`else
        chk("no_timeout_latency", 32'(rsp_cyc - t1_cyc), 23);
        chk("no_timeout_err", last_err, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int nreq;
            nreq = $urandom_range(1, 2);
            for (int j = 0; j < nreq; j++) begin
                req_t r;
                r.wr = 1'($urandom); r.io = 1'($urandom);
                r.addr = 20'($urandom); r.wd = 8'($urandom);
                r.w = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
                r.force_rd = -1;
                pend.push_back(r);
            end
            run(80);
            if (cur.wr) chk("rand_wr_mem", mem_rd(int'({cur.io, cur.io ? {4'h0, cur.addr[15:0]} : cur.addr})), cur.wd);
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_cycle_master_8088.md
# bus_cycle_master_8088

Synchronous 8088 minimum-mode bus initiator. Converts single-byte requests on a valid/ready port into T1–T4 bus cycles with READY-driven wait states, then returns completion and read data. Used as the active end of the shared 8088 bus, for example as a DMA or test master. Drives the same pins the processor model drives and talks to the existing memory/IO responders through the external address latch, transceiver and chip-select logic.

## Interface
Parameters:
- MAX_WAIT, 15: maximum TW cycles before abort. Used only when WAIT_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  bus clock; all state changes on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready are high at a rising edge
- req_write  in  1  1 = write cycle, 0 = read cycle
- req_io  in  1  1 = IO space, 0 = memory space
- req_addr  in  20  byte address; IO cycles use [15:0], and A[19:16] are driven 0
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid on reads
- rsp_err  out  1  timeout abort flag, valid with rsp_valid; always 0 without the macro
- A  out  12  address bits [19:8]
- AD  inout  8  multiplexed address/data
- ALE  out  1  address latch enable, active high
- IOM  out  1  1 = IO, 0 = memory
- RD  out  1  read strobe, active low
- WR  out  1  write strobe, active low
- DTR  out  1  1 = transmit (write), 0 = receive
- DEN  out  1  transceiver enable, active low
- READY  in  1  responder ready; low inserts wait states

## Operation
- FSM states:
  - IDLE: req_ready = 1; all bus outputs inactive.
  - On acceptance: latch the request and go to T1.
- T1:
  - ALE = 1.
  - A and AD carry req_addr.
  - IOM and DTR take their values from the request.
- T2:
  - ALE = 0.
  - Read: AD is tri-stated, RD = 0, DEN = 0.
  - Write: AD carries wdata, WR = 0, DEN = 0.
- T3: at the end of T3, sample READY.
  - READY = 1: go to T4.
  - READY = 0: go to TW.
- TW: strobes are held. Sample READY each cycle and leave for T4 on the first high.
- Read data capture: on the rising edge that leaves T3 or TW with READY = 1, register AD into rsp_rdata.
- T4:
  - RD, WR and DEN return to 1.
  - For writes, AD keeps driving wdata through T4 (hold time).
  - rsp_valid = 1 for this one cycle.
  - Next state is IDLE. There is no T4→T1 chaining, so there is at least one IDLE cycle between cycles.
- IOM, DTR and A stay stable from T1 through T4. They keep their last values in IDLE, and only the strobes are guaranteed inactive there.
- The AD output enable is asserted only in T1 and in write T2–T4. It is never asserted during read T2–T4.
- rsp_rdata holds its value until the next read capture.
- A READY change in T1, T2 or T4 is ignored.

## Timing
- Reset values (asynchronous, while RESET_N = 0):
  - ALE = 0, RD = 1, WR = 1, DEN = 1, DTR = 0, IOM = 0, A = 0, AD = Z.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - FSM = IDLE.
- req_ready rises in the first cycle after RESET_N deasserts.
- Reset during any T-state:
  - The strobes deassert and AD floats immediately.
  - No rsp_valid is produced for the aborted request.
- Latency with zero wait states: acceptance edge → T1 → T2 → T3 → T4. rsp_valid is high 4 cycles after acceptance.
- Each TW adds 1 cycle.
- Throughput: one request per 5 cycles with no wait states.
- All outputs are registered. The only exception is req_ready, which is a decode of state and is gated by RESET_N.

## Configuration
- WAIT_TIMEOUT_EN defined:
  - A 4-bit or wider counter counts consecutive TW cycles.
  - When the count reaches MAX_WAIT while READY is still 0, go to T4 with rsp_err = 1.
  - rsp_rdata is not updated on that abort.
- WAIT_TIMEOUT_EN undefined:
  - TW waits indefinitely.
  - rsp_err is tied to 0 and no counter is built.

## Test plan
- Memory read, READY = 1, req_addr = 0x81234, responder returns 0xA5:
  - T1: ALE = 1, A = 0x812, AD = 0x34, IOM = 0.
  - T2–T3: RD = 0, DEN = 0.
  - rsp_valid with rsp_rdata = 0xA5 four cycles after acceptance.
- IO write, req_addr = 0x0FF05, wdata = 0x3C:
  - IOM = 1, DTR = 1, A = 0x0FF, T1 AD = 0x05.
  - WR = 0 in T2–T3; AD = 0x3C in T2–T4.
  - Responder port 0xFF05 holds 0x3C afterwards.
- Wait states: READY held low for the 2 cycles after T3 entry.
  - Exactly 2 TW states; RD stays 0 throughout.
  - rsp_valid 6 cycles after acceptance; the data is the value present when READY rose.
- Back-to-back: req_valid held high with two queued requests.
  - Second T1 begins exactly 5 cycles after the first.
  - Exactly one IDLE cycle between the two T4/T1 states.
- Reset mid-cycle: RESET_N pulled low during T3 of a write.
  - Same cycle: WR = 1, DEN = 1, AD = Z; no rsp_valid.
  - After release: req_ready = 1 and a new read completes normally.
- WAIT_TIMEOUT_EN with MAX_WAIT = 15 and READY held low for 20 cycles:
  - Abort after 15 TW cycles with rsp_err = 1; previous rsp_rdata is unchanged.
  - Without the macro, the master is still in TW at cycle 20.
